// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm sequencing controller.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package alarm_pkg;

    // Visible state codes; 6 and 7 are illegal and recover to DISARMED
    localparam logic [2:0] ST_DISARMED    = 3'd0;
    localparam logic [2:0] ST_EXIT_DELAY  = 3'd1;
    localparam logic [2:0] ST_ARMED_AWAY  = 3'd2;
    localparam logic [2:0] ST_ARMED_NIGHT = 3'd3;
    localparam logic [2:0] ST_ENTRY_DELAY = 3'd4;
    localparam logic [2:0] ST_ALARM       = 3'd5;

    // Origin of an alarm, used to pick the re-arm target after the siren
    localparam logic MODE_AWAY  = 1'b0;
    localparam logic MODE_NIGHT = 1'b1;

    // Armed indicator covers every state from ARMED_AWAY through ALARM
    function automatic logic is_armed(input logic [2:0] s);
        return (s >= ST_ARMED_AWAY) && (s <= ST_ALARM);
    endfunction

endpackage

// File: rtl/alarm_ctrl_delay_counter.sv
// Tick-driven down counter that flags expiry of a timed state.
// Latency: expire is combinational from the count and the current tick.
// Backpressure: none; load has priority over decrement.
module delay_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_loaded_zero;

    // Load on state entry, otherwise count down one per tick until zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_loaded_zero <= 1'b0;
        end else if (load) begin
            r_cnt         <= load_val;
            r_loaded_zero <= (load_val == '0);
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A zero-length delay expires immediately, independent of tick
    assign expire = (tick && (r_cnt == CNT_W'(1))) || ((r_cnt == '0) && r_loaded_zero);

endmodule

// File: rtl/alarm_ctrl.sv
// Arm/disarm sequencer driving the alarm block's N/X mode lines and the siren.
// Latency: every output is registered, reflecting the state entered on the edge.
// Backpressure: none; requests are one-cycle strobes, late ones are dropped.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int EXIT_TICKS  = 8,
    parameter int ENTRY_TICKS = 10,
    parameter int SIREN_TICKS = 30,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       arm_away,
    input  logic       arm_night,
    input  logic       disarm,
    input  logic       W,
    input  logic       D,
    input  logic       G,
    input  logic       A,
    output logic       N,
    output logic       X,
    output logic       siren,
    output logic       armed,
    output logic       arm_err,
    output logic [2:0] state_o
);

    logic [2:0]       r_state;
    logic             r_mode;
    logic [2:0]       w_next;
    logic             w_mode_nxt;
    logic             w_secure;
    logic             w_expire;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_arm_err;
    logic             w_n;
    logic             w_x;
    logic             w_siren;
    logic             w_armed;

    assign w_secure = W & D & G;

    delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick),
        .expire   (w_expire)
    );

    // State, mode and registered outputs all update on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_DISARMED;
            r_mode  <= MODE_AWAY;
            N       <= 1'b0;
            X       <= 1'b0;
            siren   <= 1'b0;
            armed   <= 1'b0;
            arm_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_mode  <= w_mode_nxt;
            N       <= w_n;
            X       <= w_x;
            siren   <= w_siren;
            armed   <= w_armed;
            arm_err <= w_arm_err;
        end
    end

    assign state_o = r_state;

    // Next-state selection; disarm overrides every other event
    always_comb begin
        w_next    = r_state;
        w_arm_err = 1'b0;
        if (disarm) begin
            w_next = ST_DISARMED;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    if (arm_away && arm_night) begin
                        w_arm_err = 1'b1;
                    end else if (arm_away || arm_night) begin
                        if (!w_secure)     w_arm_err = 1'b1;
                        else if (arm_away) w_next    = ST_EXIT_DELAY;
                        else               w_next    = ST_ARMED_NIGHT;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (w_expire) w_next = ST_ARMED_AWAY;
                end
                ST_ARMED_AWAY: begin
                    if (A) w_next = (!D && W && G) ? ST_ENTRY_DELAY : ST_ALARM;
                end
                ST_ENTRY_DELAY: begin
                    if (!W || !G || w_expire) w_next = ST_ALARM;
                end
                ST_ARMED_NIGHT: begin
                    if (A) w_next = ST_ALARM;
                end
                ST_ALARM: begin
                    if (w_expire) w_next = (r_mode == MODE_NIGHT) ? ST_ARMED_NIGHT : ST_ARMED_AWAY;
                end
                default: w_next = ST_DISARMED;
            endcase
        end
    end

    // Counter reload and alarm-origin tracking keyed off the state being entered
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = '0;
        case (w_next)
            ST_EXIT_DELAY:  w_load_val = CNT_W'(EXIT_TICKS);
            ST_ENTRY_DELAY: w_load_val = CNT_W'(ENTRY_TICKS);
            ST_ALARM:       w_load_val = CNT_W'(SIREN_TICKS);
            default:        w_load_val = '0;
        endcase
        w_mode_nxt = r_mode;
        if (w_next == ST_ARMED_AWAY)  w_mode_nxt = MODE_AWAY;
        if (w_next == ST_ARMED_NIGHT) w_mode_nxt = MODE_NIGHT;
    end

    // Output decode from the next state so the registered outputs match state_o
    always_comb begin
        w_n     = (w_next == ST_ARMED_NIGHT) ||
                  ((w_next == ST_ALARM) && (w_mode_nxt == MODE_NIGHT));
        w_x     = (w_next == ST_ARMED_AWAY) || (w_next == ST_ENTRY_DELAY) ||
                  ((w_next == ST_ALARM) && (w_mode_nxt == MODE_AWAY));
        w_siren = (w_next == ST_ALARM);
        w_armed = is_armed(w_next);
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       arm_away = 1'b0;
    logic       arm_night = 1'b0;
    logic       disarm = 1'b0;
    logic       W = 1'b1;
    logic       D = 1'b1;
    logic       G = 1'b1;
    logic       A = 1'b0;
    logic       N;
    logic       X;
    logic       siren;
    logic       armed;
    logic       arm_err;
    logic [2:0] state_o;

    int tests = 0;
    int fails = 0;
    int phase = 0;

    alarm_ctrl #(
        .EXIT_TICKS  (3),
        .ENTRY_TICKS (4),
        .SIREN_TICKS (5),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .arm_away  (arm_away),
        .arm_night (arm_night),
        .disarm    (disarm),
        .W         (W),
        .D         (D),
        .G         (G),
        .A         (A),
        .N         (N),
        .X         (X),
        .siren     (siren),
        .armed     (armed),
        .arm_err   (arm_err),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; tick is high on every 4th edge
    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        tick  = (phase == 0);
    endtask

    // Advance through the next edge that samples tick=1
    task automatic to_tick();
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            hit = tick;
            step();
            if (hit) break;
        end
        tests++;
        if (!hit) begin
            fails++;
            $error("FAIL tick_wait observed=0 expected=1");
        end
    endtask

    // Stop just before an edge that will sample tick=1
    task automatic until_tick();
        for (int k = 0; k < 8 && !tick; k++) step();
    endtask

    initial begin
        step();
        step();
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_N", 8'(N), 8'd0);
        chk("rst_X", 8'(X), 8'd0);
        chk("rst_siren", 8'(siren), 8'd0);
        chk("rst_armed", 8'(armed), 8'd0);
        chk("rst_err", 8'(arm_err), 8'd0);
        reset = 1'b0;
        step();

        // Arm away with all sensors secure: exit delay of 3 ticks
        arm_away = 1'b1; step(); arm_away = 1'b0;
        chk("exit_state", 8'(state_o), 8'd1);
        chk("exit_X", 8'(X), 8'd0);
        chk("exit_armed", 8'(armed), 8'd0);
        to_tick(); to_tick();
        until_tick();
        chk("exit_before_3rd", 8'(state_o), 8'd1);
        step();
        chk("away_state", 8'(state_o), 8'd2);
        chk("away_X", 8'(X), 8'd1);
        chk("away_armed", 8'(armed), 8'd1);

        // Arm request while armed is ignored
        arm_night = 1'b1; step(); arm_night = 1'b0;
        chk("ign_state", 8'(state_o), 8'd2);
        chk("ign_err", 8'(arm_err), 8'd0);

        // Door trip opens entry delay, disarm after 2 ticks
        D = 1'b0; A = 1'b1; step(); A = 1'b0;
        chk("entry_state", 8'(state_o), 8'd4);
        chk("entry_X", 8'(X), 8'd1);
        to_tick(); to_tick();
        chk("entry_2t_state", 8'(state_o), 8'd4);
        chk("entry_2t_siren", 8'(siren), 8'd0);
        disarm = 1'b1; step(); disarm = 1'b0; D = 1'b1;
        chk("dis_state", 8'(state_o), 8'd0);
        chk("dis_siren", 8'(siren), 8'd0);
        chk("dis_armed", 8'(armed), 8'd0);

        // Arm night with an open window is rejected for one cycle
        W = 1'b0; arm_night = 1'b1; step(); arm_night = 1'b0;
        chk("rej_err", 8'(arm_err), 8'd1);
        chk("rej_state", 8'(state_o), 8'd0);
        chk("rej_N", 8'(N), 8'd0);
        step();
        chk("rej_err_drop", 8'(arm_err), 8'd0);
        W = 1'b1;

        // Both arm requests together are rejected
        arm_away = 1'b1; arm_night = 1'b1; step(); arm_away = 1'b0; arm_night = 1'b0;
        chk("both_err", 8'(arm_err), 8'd1);
        chk("both_state", 8'(state_o), 8'd0);

        // Disarm together with an arm request: stay, no error
        arm_away = 1'b1; disarm = 1'b1; step(); arm_away = 1'b0; disarm = 1'b0;
        chk("disarm_arm_state", 8'(state_o), 8'd0);
        chk("disarm_arm_err", 8'(arm_err), 8'd0);

        // Entry delay running to expiry
        arm_away = 1'b1; step(); arm_away = 1'b0;
        to_tick(); to_tick(); to_tick();
        chk("away2_state", 8'(state_o), 8'd2);
        D = 1'b0; A = 1'b1; step(); A = 1'b0; D = 1'b1;
        chk("entry2_state", 8'(state_o), 8'd4);
        to_tick(); to_tick(); to_tick();
        chk("entry2_3t", 8'(state_o), 8'd4);
        to_tick();
        chk("alarm_state", 8'(state_o), 8'd5);
        chk("alarm_siren", 8'(siren), 8'd1);
        chk("alarm_X", 8'(X), 8'd1);
        chk("alarm_N", 8'(N), 8'd0);
        disarm = 1'b1; step(); disarm = 1'b0;
        chk("alarm_dis_state", 8'(state_o), 8'd0);
        chk("alarm_dis_siren", 8'(siren), 8'd0);

        // Night arming, trip, siren expiry and re-trip with A held
        arm_night = 1'b1; step(); arm_night = 1'b0;
        chk("night_state", 8'(state_o), 8'd3);
        chk("night_N", 8'(N), 8'd1);
        chk("night_armed", 8'(armed), 8'd1);
        A = 1'b1; step(); A = 1'b0;
        chk("ntrip_state", 8'(state_o), 8'd5);
        chk("ntrip_N", 8'(N), 8'd1);
        chk("ntrip_X", 8'(X), 8'd0);
        chk("ntrip_siren", 8'(siren), 8'd1);
        to_tick(); to_tick(); to_tick(); to_tick();
        chk("siren_4t", 8'(state_o), 8'd5);
        until_tick();
        A = 1'b1;
        step();
        chk("rearm_state", 8'(state_o), 8'd3);
        chk("rearm_siren", 8'(siren), 8'd0);
        chk("rearm_N", 8'(N), 8'd1);
        step();
        chk("retrip_state", 8'(state_o), 8'd5);
        A = 1'b0;
        disarm = 1'b1; step(); disarm = 1'b0;

        // Escalation: window opens during entry delay
        arm_away = 1'b1; step(); arm_away = 1'b0;
        to_tick(); to_tick(); to_tick();
        D = 1'b0; A = 1'b1; step(); A = 1'b0; D = 1'b1;
        chk("esc_entry", 8'(state_o), 8'd4);
        step();
        chk("esc_wait", 8'(state_o), 8'd4);
        W = 1'b0; step(); W = 1'b1;
        chk("esc_state", 8'(state_o), 8'd5);
        chk("esc_siren", 8'(siren), 8'd1);

        // Asynchronous reset between edges while the siren is sounding
        #1;
        reset = 1'b1;
        #1;
        chk("areset_state", 8'(state_o), 8'd0);
        chk("areset_siren", 8'(siren), 8'd0);
        step();
        reset = 1'b0;
        step();
        arm_away = 1'b1; step(); arm_away = 1'b0;
        chk("fresh_exit", 8'(state_o), 8'd1);
        to_tick(); to_tick();
        chk("fresh_2t", 8'(state_o), 8'd1);
        to_tick();
        chk("fresh_away", 8'(state_o), 8'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
